// File: rtl/gru_request_arbiter.sv
// Round-robin arbiter that shares one GRU_Model among NUM_REQ channels, runs the
// model's four-phase start/done handshake and returns tagged predictions.
`timescale 1ns/1ps

module gru_request_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int INPUT_FEATURES  = 3,
  parameter int SEQUENCE_LENGTH = 3,
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 2,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int SEQ_W           = SEQUENCE_LENGTH * INPUT_FEATURES * DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*SEQ_W-1:0] i_seq_flat,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic                     o_model_start,
  output logic [SEQ_W-1:0]         o_model_seq_flat,
  input  logic                     i_model_done,
  input  logic [DATA_WIDTH-1:0]    i_model_prediction,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output logic [ID_W-1:0]          o_resp_id,
  output logic [DATA_WIDTH-1:0]    o_resp_data,
  output logic                     o_resp_err,
  output logic                     o_busy,
  output logic                     o_fault
);

  // state      | meaning
  // S_IDLE     | waiting for any request; grants on the edge it sees one
  // S_RUN      | start held high, waiting for done to rise
  // S_RELEASE  | start dropped, waiting for done to fall
  // S_RESP     | prediction response offered, waiting for ready
  // S_FAULT_RESP | timeout error response offered, waiting for ready
  // S_FAULT    | model hung; parked until reset
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_RELEASE, S_RESP, S_FAULT_RESP, S_FAULT
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic [DATA_WIDTH-1:0]  pred_q, pred_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   fault_q, fault_d;

  logic                   req_any;
  logic [ID_W-1:0]        pick_id;
  logic [ID_W-1:0]        cand;
  logic                   timeout;

  // Scan upward from the channel after the last winner, wrapping around.
  always_comb begin
    req_any = 1'b0;
    pick_id = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!req_any && i_req[cand]) begin
        req_any = 1'b1;
        pick_id = cand;
      end
    end
  end

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    seq_d   = seq_q;
    pred_d  = pred_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    grant_d = '0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          grant_d = NUM_REQ'(1) << pick_id;
          seq_d   = i_seq_flat[int'(pick_id)*SEQ_W +: SEQ_W];
          id_d    = pick_id;
          ptr_d   = pick_id;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN, S_RELEASE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A hung model takes priority over a done edge seen on the same cycle.
        if (timeout) begin
          pred_d  = '0;
          fault_d = 1'b1;
          state_d = S_FAULT_RESP;
        end else if (state_q == S_RUN) begin
          if (i_model_done) begin
            pred_d  = i_model_prediction;
            state_d = S_RELEASE;
          end
        end else if (!i_model_done) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_resp_ready) state_d = S_IDLE;
      end
      S_FAULT_RESP: begin
        if (i_resp_ready) state_d = S_FAULT;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      seq_q   <= '0;
      pred_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      seq_q   <= seq_d;
      pred_q  <= pred_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      fault_q <= fault_d;
    end
  end

  // Handshake outputs decode straight from state so reset drops them at once.
  assign o_grant          = grant_q;
  assign o_model_start    = (state_q == S_RUN);
  assign o_model_seq_flat = seq_q;
  assign o_resp_valid     = (state_q == S_RESP) || (state_q == S_FAULT_RESP);
  assign o_resp_id        = id_q;
  assign o_resp_data      = pred_q;
  assign o_resp_err       = (state_q == S_FAULT_RESP);
  assign o_busy           = (state_q != S_IDLE);
  assign o_fault          = fault_q;

endmodule

// File: tb/tb_gru_request_arbiter.sv
// Directed bench for gru_request_arbiter: table of single transactions plus
// round-robin, backpressure, handshake-release, timeout and reset sequences.
`timescale 1ns/1ps

module tb_gru_request_arbiter;

  localparam int DW    = 32;
  localparam int NR    = 4;
  localparam int SEQ_W = 3 * 3 * DW;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     i_req;
  logic [NR*SEQ_W-1:0] i_seq_flat;
  logic [NR-1:0]     o_grant;
  logic              o_model_start;
  logic [SEQ_W-1:0]  o_model_seq_flat;
  logic              i_model_done;
  logic [DW-1:0]     i_model_prediction;
  logic              o_resp_valid;
  logic              i_resp_ready;
  logic [1:0]        o_resp_id;
  logic [DW-1:0]     o_resp_data;
  logic              o_resp_err;
  logic              o_busy;
  logic              o_fault;

  gru_request_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_seq_flat(i_seq_flat),
    .o_grant(o_grant), .o_model_start(o_model_start),
    .o_model_seq_flat(o_model_seq_flat), .i_model_done(i_model_done),
    .i_model_prediction(i_model_prediction), .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready), .o_resp_id(o_resp_id),
    .o_resp_data(o_resp_data), .o_resp_err(o_resp_err),
    .o_busy(o_busy), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  logic [330:0] all_out;
  assign all_out = {o_grant, o_model_start, o_model_seq_flat, o_resp_valid,
                    o_resp_id, o_resp_data, o_resp_err, o_busy, o_fault};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_id;
    int          dly;
    logic [31:0] pred;
  } vec_t;

  vec_t tbl [6];
  logic [NR*SEQ_W-1:0] base_seq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [SEQ_W-1:0] seq_pat(input int k);
    logic [SEQ_W-1:0] r;
    r = '0;
    for (int j = 0; j < 9; j++)
      r[j*32 +: 32] = 32'hA000_0000 | 32'(k << 8) | 32'(j);
    return r;
  endfunction

  // Entered one tick after the grant (DUT in RUN); leaves on the acceptance tick.
  task automatic run_txn(input int dly, input int hold, input logic [31:0] pred,
                         input int rwait, input logic [1:0] exp_id);
    repeat (dly) tick();
    check("start_in_run", {o_model_start, o_busy}, 2'b11);
    i_model_done = 1'b1;
    i_model_prediction = pred;
    tick();
    check("start_drop", o_model_start, 1'b0);
    i_model_prediction = 32'hDEAD_BEEF;
    for (int h = 0; h < hold; h++) begin
      check("release_no_valid", {o_resp_valid, o_model_start}, 2'b00);
      tick();
    end
    i_model_done = 1'b0;
    tick();
    check("resp", {o_resp_valid, o_resp_id, o_resp_data, o_resp_err},
          {1'b1, exp_id, pred, 1'b0});
    for (int w = 0; w < rwait; w++) begin
      tick();
      check("resp_stable", {o_resp_valid, o_resp_id, o_resp_data, o_resp_err, o_grant, o_model_start},
            {1'b1, exp_id, pred, 1'b0, 4'b0000, 1'b0});
    end
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;
    check("accept", {o_resp_valid, o_grant, o_model_start, o_busy}, 7'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0010, 4'b0010, 2'd1, 40, 32'h3F80_0000};
    tbl[1] = '{4'b1001, 4'b1000, 2'd3,  3, 32'h4000_0000};
    tbl[2] = '{4'b1001, 4'b0001, 2'd0,  1, 32'h4040_0000};
    tbl[3] = '{4'b0101, 4'b0100, 2'd2,  0, 32'hC080_0000};
    tbl[4] = '{4'b0011, 4'b0001, 2'd0,  7, 32'h3F00_0000};
    tbl[5] = '{4'b1000, 4'b1000, 2'd3,  2, 32'h1234_5678};
    for (int k = 0; k < NR; k++) base_seq[k*SEQ_W +: SEQ_W] = seq_pat(k);

    rstn = 1'b0;
    i_req = '0;
    i_seq_flat = base_seq;
    i_model_done = 1'b0;
    i_model_prediction = '0;
    i_resp_ready = 1'b0;
    repeat (3) tick();
    check("reset_outputs", all_out, 331'b0);
    rstn = 1'b1;
    tick();
    check("idle_after_reset", all_out, 331'b0);

    // Single transactions; pointer carries over between rows.
    for (int v = 0; v < 6; v++) begin
      i_req = tbl[v].req;
      tick();
      check("tbl_grant", o_grant, tbl[v].exp_grant);
      check("tbl_seq", o_model_seq_flat, seq_pat(int'(tbl[v].exp_id)));
      i_req = '0;
      i_seq_flat = ~base_seq;
      tick();
      check("tbl_grant_pulse", o_grant, 4'b0000);
      check("tbl_seq_held", o_model_seq_flat, seq_pat(int'(tbl[v].exp_id)));
      i_seq_flat = base_seq;
      run_txn(tbl[v].dly, 0, tbl[v].pred, 0, tbl[v].exp_id);
    end

    // Round robin with all channels requesting continuously.
    i_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("rr_grant", o_grant, 4'b0001 << (n % 4));
      check("rr_seq", o_model_seq_flat, seq_pat(n % 4));
      if (n == 4) i_req = '0;
      run_txn(2, 0, 32'h100 + 32'(n), 0, 2'(n % 4));
    end

    // Backpressure while other channels keep requesting.
    i_req = 4'b0100;
    tick();
    check("bp_grant", o_grant, 4'b0100);
    i_req = 4'b1011;
    run_txn(4, 0, 32'h7F7F_FFFF, 20, 2'd2);
    tick();
    check("bp_next_grant", o_grant, 4'b1000);
    i_req = '0;
    run_txn(1, 0, 32'h0BAD_F00D, 0, 2'd3);

    // Model keeps done high after start falls.
    i_req = 4'b0001;
    tick();
    check("hs_grant", o_grant, 4'b0001);
    i_req = '0;
    run_txn(6, 5, 32'hBF80_0000, 0, 2'd0);

    // Hung model.
    i_req = 4'b0010;
    tick();
    check("to_grant", o_grant, 4'b0010);
    i_req = '0;
    begin
      logic bad;
      bad = 1'b0;
      repeat (63) begin
        tick();
        if (o_resp_valid || !o_model_start || o_fault) bad = 1'b1;
      end
      check("to_run_window", bad, 1'b0);
      tick();
      check("to_err_resp", {o_resp_valid, o_resp_err, o_resp_id, o_resp_data, o_model_start, o_fault},
            {1'b1, 1'b1, 2'd1, 32'h0, 1'b0, 1'b1});
      i_resp_ready = 1'b1;
      tick();
      i_resp_ready = 1'b0;
      check("to_fault_state", {o_resp_valid, o_busy, o_fault}, 3'b011);
      i_req = 4'b0001;
      bad = 1'b0;
      repeat (10) begin
        tick();
        if (o_grant != 4'b0000 || o_model_start || !o_fault || !o_busy) bad = 1'b1;
      end
      check("fault_no_grant", bad, 1'b0);
    end
    rstn = 1'b0;
    #1;
    check("fault_reset", all_out, 331'b0);
    tick();
    i_req = 4'b0101;
    rstn = 1'b1;
    tick();
    check("post_fault_grant", o_grant, 4'b0001);
    i_req = '0;
    run_txn(2, 0, 32'h4120_0000, 0, 2'd0);

    // Reset in the middle of RUN.
    i_req = 4'b0010;
    tick();
    check("mr_grant", o_grant, 4'b0010);
    i_req = '0;
    repeat (10) tick();
    check("mr_running", o_model_start, 1'b1);
    rstn = 1'b0;
    i_req = 4'b0100;
    #1;
    check("mr_async_reset", all_out, 331'b0);
    repeat (3) begin
      tick();
      check("mr_reset_hold", all_out, 331'b0);
    end
    rstn = 1'b1;
    tick();
    check("mr_grant_after", o_grant, 4'b0100);
    check("mr_seq_after", o_model_seq_flat, seq_pat(2));
    i_req = '0;
    run_txn(1, 0, 32'h4248_0000, 0, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
